// File: rtl/alu_result_select_pkg.sv
// Shared encodings and default parameters for the ALU result selector.
// Channel indices follow the order of the ALU result bus.
package alu_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } sel_state_t;

  localparam int DEF_WIDTH   = 24;
  localparam int DEF_NUM_IN  = 6;
  localparam int DEF_SEL_W   = 3;
  localparam int DEF_TIMEOUT = 15;

  localparam int SEL_AND  = 0;
  localparam int SEL_OR   = 1;
  localparam int SEL_ADD  = 2;
  localparam int SEL_LESS = 3;
  localparam int SEL_MUL  = 4;
  localparam int SEL_XOR  = 5;

endpackage

// File: rtl/alu_result_select_if.sv
// Request/result bundle between the ALU result producer/consumer and the selector.
// The master side drives channel data, the request and the consumer accept.
interface alu_sel_if #(
  parameter int WIDTH  = alu_sel_pkg::DEF_WIDTH,
  parameter int NUM_IN = alu_sel_pkg::DEF_NUM_IN,
  parameter int SEL_W  = alu_sel_pkg::DEF_SEL_W
) ();

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [SEL_W-1:0]        selector;
  logic                    start;
  logic                    busy;
  logic [WIDTH-1:0]        result;
  logic                    result_valid;
  logic                    result_ready;
  logic                    error;

  modport master (
    output in_data, in_valid, selector, start, result_ready,
    input  busy, result, result_valid, error
  );

  modport slave (
    input  in_data, in_valid, selector, start, result_ready,
    output busy, result, result_valid, error
  );

endinterface

// File: rtl/alu_result_select_wait_timer.sv
// Wait counter for the selector: counts cycles without a valid result and
// flags the last permitted wait cycle.
module wait_timer #(
  parameter int TIMEOUT = alu_sel_pkg::DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tc = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/alu_result_select.sv
// Selects one ALU result channel per request, waits for its valid flag with a
// bounded timeout and holds the registered result until the consumer accepts it.
//
// state | meaning
// IDLE  | waiting for start; selector captured on start
// WAIT  | waiting for the selected channel's valid, bounded by TIMEOUT
// DONE  | result/error presented, held until result_ready
module alu_result_select
  import alu_sel_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic     clk,
  input logic     rst,
  alu_sel_if.slave bus
);

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

  sel_state_t       state, state_nxt;
  logic [SEL_W-1:0] sel_reg;
  logic [WIDTH-1:0] result_q;
  logic             error_q;
  logic             sel_legal;
  logic             chan_valid;
  logic [WIDTH-1:0] chan_data;
  logic             tmr_tc;

  assign sel_legal = ({1'b0, bus.selector} < NUM_IN_W);

  // Only the registered channel is looked at; every other channel is ignored.
  always_comb begin
    chan_valid = 1'b0;
    chan_data  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_reg == SEL_W'(k)) begin
        chan_valid = bus.in_valid[k];
        chan_data  = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_WAIT),
    .en  (state == ST_WAIT && !chan_valid),
    .tc  (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = sel_legal ? ST_WAIT : ST_DONE;
      ST_WAIT: if (chan_valid || tmr_tc) state_nxt = ST_DONE;
      ST_DONE: if (bus.result_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (state != ST_IDLE);
    bus.result_valid = (state == ST_DONE);
  end

  // Result/error only change on DONE entry; a valid beats a coincident timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_reg  <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            sel_reg <= bus.selector;
            if (!sel_legal) begin
              result_q <= '0;
              error_q  <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (chan_valid) begin
            result_q <= chan_data;
            error_q  <= 1'b0;
          end else if (tmr_tc) begin
            result_q <= '0;
            error_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.error  = error_q;

endmodule

// File: tb/tb_alu_result_select.sv
// Directed bench for alu_result_select: hand-computed vectors covering capture,
// illegal selector, timeout boundary, DONE hold and reset mid-transaction.
module tb_alu_result_select;
  import alu_sel_pkg::*;

  localparam int WIDTH  = 24;
  localparam int NUM_IN = 6;
  localparam int SEL_W  = 3;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   n_wait;

  alu_sel_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

  alu_result_select #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [WIDTH-1:0] d, input logic v);
    bus.in_data[k*WIDTH +: WIDTH] = d;
    bus.in_valid[k] = v;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.in_data = '0;
    bus.in_valid = '0;
    bus.selector = '0;
    bus.start = 1'b0;
    bus.result_ready = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rv", 32'(bus.result_valid), 32'd0);
    chk("rst_res", 32'(bus.result), 32'd0);
    chk("rst_err", 32'(bus.error), 32'd0);
    rst = 1'b0;

    // ADD channel, valid one cycle after start
    bus.selector = 3'(SEL_ADD);
    bus.start = 1'b1;
    set_ch(SEL_ADD, 24'h001234, 1'b1);  // coincident with start: must not be captured
    step();
    bus.start = 1'b0;
    chk("add_wait_busy", 32'(bus.busy), 32'd1);
    chk("add_wait_rv", 32'(bus.result_valid), 32'd0);
    chk("add_wait_res", 32'(bus.result), 32'd0);
    step();
    set_ch(SEL_ADD, 24'h0, 1'b0);
    chk("add_rv", 32'(bus.result_valid), 32'd1);
    chk("add_res", 32'(bus.result), 32'h001234);
    chk("add_err", 32'(bus.error), 32'd0);
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    chk("add_hs_rv", 32'(bus.result_valid), 32'd0);
    chk("add_hs_busy", 32'(bus.busy), 32'd0);
    chk("add_hold_res", 32'(bus.result), 32'h001234);

    // Illegal selector goes straight to DONE with error
    bus.selector = 3'b110;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("ill_rv", 32'(bus.result_valid), 32'd1);
    chk("ill_res", 32'(bus.result), 32'd0);
    chk("ill_err", 32'(bus.error), 32'd1);
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;

    // MUL never valid: 15 WAIT cycles then timeout; other channels stay ignored
    bus.selector = 3'(SEL_MUL);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    set_ch(SEL_AND, 24'h111111, 1'b1);
    set_ch(SEL_XOR, 24'h555555, 1'b1);
    n_wait = 0;
    while (bus.busy && !bus.result_valid && n_wait < 40) begin
      n_wait++;
      step();
    end
    chk("to_wait_cycles", 32'(n_wait), 32'd15);
    chk("to_rv", 32'(bus.result_valid), 32'd1);
    chk("to_res", 32'(bus.result), 32'd0);
    chk("to_err", 32'(bus.error), 32'd1);
    bus.in_valid = '0;
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;

    // MUL valid on the 15th WAIT cycle: valid wins over timeout
    bus.selector = 3'(SEL_MUL);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("last_still_wait", 32'(bus.result_valid), 32'd0);
    set_ch(SEL_MUL, 24'hABCDEF, 1'b1);
    step();
    set_ch(SEL_MUL, 24'h000000, 1'b0);
    chk("last_rv", 32'(bus.result_valid), 32'd1);
    chk("last_res", 32'(bus.result), 32'hABCDEF);
    chk("last_err", 32'(bus.error), 32'd0);

    // DONE hold: ready low 5 cycles, data changing and start pulsing
    for (int i = 0; i < 5; i++) begin
      set_ch(SEL_MUL, 24'(i * 24'h010101 + 24'h0F0F0F), 1'b1);
      bus.selector = 3'(SEL_OR);
      bus.start = (i % 2 == 0);
      step();
      chk("hold_res", 32'(bus.result), 32'hABCDEF);
      chk("hold_rv", 32'(bus.result_valid), 32'd1);
    end
    bus.start = 1'b0;
    bus.in_valid = '0;
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    chk("hold_hs_busy", 32'(bus.busy), 32'd0);

    bus.selector = 3'(SEL_OR);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("next_busy", 32'(bus.busy), 32'd1);
    set_ch(SEL_OR, 24'h5A5A5A, 1'b1);
    step();
    bus.in_valid = '0;
    chk("next_res", 32'(bus.result), 32'h5A5A5A);
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;

    // Reset in the 3rd WAIT cycle discards the transaction
    bus.selector = 3'(SEL_XOR);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    set_ch(SEL_XOR, 24'h777777, 1'b1);
    step();
    chk("rstw_busy", 32'(bus.busy), 32'd0);
    chk("rstw_rv", 32'(bus.result_valid), 32'd0);
    chk("rstw_res", 32'(bus.result), 32'd0);
    chk("rstw_err", 32'(bus.error), 32'd0);
    rst = 1'b0;
    bus.in_valid = '0;
    step();
    chk("rstw_no_spur_rv", 32'(bus.result_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
